// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and defaults for the scoreboard hazard unit
package hazard_scoreboard_pkg;

    localparam int NREG_DEF  = 32;
    localparam int NSRC_DEF  = 3;
    localparam int NLONG_DEF = 2;
    localparam int LAT_W_DEF = 6;
    localparam int LAT0_DEF  = 3;
    localparam int LAT1_DEF  = 34;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_LONG = 2'd2
    } hazard_issue_kind_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        UNIT_MULT = 1'b0,
        UNIT_DIV  = 1'b1
    } long_unit_t;

    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic stallM;
        logic stallW;
        logic flushF;
        logic flushD;
        logic flushE;
        logic flushM;
    } hazard_control_t;

    // A single long unit still needs a one-bit select port.
    function automatic int unitIdxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_long_unit_timer.sv
// rtl/hazard_scoreboard_long_unit_timer.sv - countdown tracking one long-latency unit
module long_unit_timer #(
    parameter int LAT_W = 6,
    parameter int LAT   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic start,
    output logic busy
);

    // The issue cycle itself is the first of the LAT cycles.
    localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LAT - 1);

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - registered-scoreboard hazard unit for the F/D/E/M/W pipeline
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int NSRC  = NSRC_DEF,
    parameter int NLONG = NLONG_DEF,
    parameter int LAT_W = LAT_W_DEF,
    parameter int LAT0  = LAT0_DEF,
    parameter int LAT1  = LAT1_DEF,
    localparam int IDX_W  = $clog2(NREG),
    localparam int UNIT_W = unitIdxW(NLONG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ireq_valid,
    input  logic                    iresp_data_ok,
    input  logic                    dreq_valid,
    input  logic                    dresp_data_ok,
    input  logic [NSRC*IDX_W-1:0]   srcD,
    input  logic [NSRC-1:0]         srcD_used,
    input  logic                    issue_valid,
    input  logic [IDX_W-1:0]        issue_dst,
    input  logic                    issue_regwrite,
    input  logic [1:0]              issue_kind,
    input  logic [UNIT_W-1:0]       issue_unit,
    input  logic [IDX_W-1:0]        dstE,
    input  logic [IDX_W-1:0]        dstM,
    input  logic                    regwriteE,
    input  logic                    regwriteM,
    input  logic                    readyE,
    input  logic                    readyM,
    input  logic                    wb_valid,
    input  logic [IDX_W-1:0]        wb_dst,
    input  logic                    redirectE,
    input  logic                    flush_all,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    stallE,
    output logic                    stallM,
    output logic                    stallW,
    output logic                    flushF,
    output logic                    flushD,
    output logic                    flushE,
    output logic                    flushM,
    output logic [NSRC*2-1:0]       fwd_sel,
    output logic [NREG-1:0]         busy_vec
);

    hazard_control_t   ctrl;
    hazard_control_t   ctrlOut;
    logic [NREG-1:0]   busyQ;
    logic [NREG-1:0]   busyNext;
    logic [NLONG-1:0]  unitBusy;
    logic              longEQ;
    logic              rawStall;
    logic              structStall;
    logic              hazStall;
    logic              imemWait;
    logic              dmemWait;
    logic              longWait;
    logic              flushAllEff;
    logic              issueFire;
    logic              isLongIssue;
    logic [NSRC*2-1:0] fwdComb;
    logic [IDX_W-1:0]  srcIdx;
    fwd_sel_t          srcSel;

    assign imemWait    = ireq_valid & ~iresp_data_ok;
    assign dmemWait    = dreq_valid & ~dresp_data_ok;
    assign longWait    = longEQ & ~readyE;
    // The source holds flush_all until a data-memory wait lets it through.
    assign flushAllEff = flush_all & ~dmemWait;
    assign isLongIssue = (issue_kind == KIND_LONG);
    assign structStall = issue_valid & isLongIssue & unitBusy[issue_unit];
    assign hazStall    = rawStall | structStall;

    always_comb begin
        rawStall = 1'b0;
        fwdComb  = '0;
        srcIdx   = '0;
        srcSel   = FWD_RF;
        for (int s = 0; s < NSRC; s++) begin
            srcIdx = srcD[s*IDX_W +: IDX_W];
            srcSel = FWD_RF;
            if (srcD_used[s] && (srcIdx != '0)) begin
                if (regwriteE && readyE && (srcIdx == dstE)) begin
                    srcSel = FWD_E;
                end else if (regwriteM && readyM && (srcIdx == dstM)) begin
                    srcSel = FWD_M;
                end else if (busyQ[srcIdx] && issue_valid) begin
                    rawStall = 1'b1;
                end
            end
            fwdComb[s*2 +: 2] = srcSel;
        end
    end

    always_comb begin
        ctrl        = '0;
        ctrl.stallF = hazStall | imemWait | dmemWait | longWait;
        ctrl.stallD = hazStall | dmemWait | longWait;
        ctrl.stallE = dmemWait | longWait;
        ctrl.stallM = dmemWait;
        ctrl.stallW = 1'b0;
        ctrl.flushF = redirectE;
        ctrl.flushD = redirectE;
        ctrl.flushE = ctrl.stallD & ~ctrl.stallE;
        ctrl.flushM = longWait & ~dmemWait;
        if (flushAllEff) begin
            ctrl.stallF = 1'b0;
            ctrl.stallD = 1'b0;
            ctrl.stallE = 1'b0;
            ctrl.stallM = 1'b0;
            ctrl.flushF = 1'b1;
            ctrl.flushD = 1'b1;
            ctrl.flushE = 1'b1;
            ctrl.flushM = 1'b1;
        end
    end

    assign issueFire = issue_valid & ~ctrl.stallD & ~ctrl.flushD;

    // Outputs go quiet the moment reset drops, not at the next edge.
    assign ctrlOut = reset ? ctrl : '0;
    assign fwd_sel = reset ? fwdComb : '0;
    assign stallF  = ctrlOut.stallF;
    assign stallD  = ctrlOut.stallD;
    assign stallE  = ctrlOut.stallE;
    assign stallM  = ctrlOut.stallM;
    assign stallW  = ctrlOut.stallW;
    assign flushF  = ctrlOut.flushF;
    assign flushD  = ctrlOut.flushD;
    assign flushE  = ctrlOut.flushE;
    assign flushM  = ctrlOut.flushM;

    always_comb begin
        busyNext = busyQ;
        if (wb_valid) begin
            busyNext[wb_dst] = 1'b0;
        end
        if (issueFire && issue_regwrite && (issue_dst != '0)) begin
            busyNext[issue_dst] = 1'b1;
        end
        busyNext[0] = 1'b0;
        if (flushAllEff) begin
            busyNext = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busyQ  <= '0;
            longEQ <= 1'b0;
        end else begin
            busyQ <= busyNext;
            if (flushAllEff) begin
                longEQ <= 1'b0;
            end else if (!ctrl.stallE) begin
                longEQ <= issueFire & isLongIssue;
            end
        end
    end

    assign busy_vec = busyQ;

    for (genvar u = 0; u < NLONG; u++) begin : genTimer
        long_unit_timer #(
            .LAT_W (LAT_W),
            .LAT   ((u == 0) ? LAT0 : LAT1)
        ) uTimer (
            .clk   (clk),
            .reset (reset),
            .clear (flushAllEff),
            .start (issueFire & isLongIssue & (issue_unit == UNIT_W'(u))),
            .busy  (unitBusy[u])
        );
    end

endmodule
